// File: rtl/complement_base_arbiter_if.sv
// Handshake bundle between per-lane base sources, the arbiter and the complement pipeline.
interface complement_base_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int SRC_WIDTH  = 2
);
    logic [NUM_REQ-1:0]            in_valid;
    logic [NUM_REQ-1:0]            in_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] in_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [DATA_WIDTH-1:0]         out_data;
    logic [SRC_WIDTH-1:0]          out_source;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_source
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_source
    );
endinterface

// File: rtl/complement_base_arbiter.sv
// Round-robin arbiter feeding one base stream into a one-entry output stage.
// Optional COMPLEMENT_ARB_BURST_EN lets the owner keep the grant for up to BURST_LEN bases.
module complement_base_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int SRC_WIDTH  = 2,
    parameter int BURST_LEN  = 4
) (
    input logic                      clock,
    input logic                      reset_n,
    complement_base_arbiter_if.slave bus
);
    if (BURST_LEN < 1 || (1 << SRC_WIDTH) < NUM_REQ || NUM_REQ < 2) begin : g_param_check
        $error("complement_base_arbiter: illegal parameter combination");
    end

    logic [SRC_WIDTH-1:0]  ptr;
    logic [SRC_WIDTH-1:0]  next_ptr;
    logic [SRC_WIDTH-1:0]  start;
    logic [SRC_WIDTH-1:0]  offset;
    logic [SRC_WIDTH-1:0]  grant;
    logic [SRC_WIDTH:0]    sum;
    logic [2*NUM_REQ-1:0]  dbl;
    logic [NUM_REQ-1:0]    rot;
    logic                  slot_free;
    logic                  any_valid;
    logic                  xfer;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [SRC_WIDTH-1:0]  out_source_q;
    logic [DATA_WIDTH-1:0] sel_data;

    assign slot_free = !out_valid_q || bus.out_ready;
    assign any_valid = |bus.in_valid;
    // in_ready drops the instant reset asserts, not at the next edge
    assign xfer      = slot_free && any_valid && reset_n;
    assign next_ptr  = (ptr == SRC_WIDTH'(NUM_REQ - 1)) ? '0 : ptr + 1'b1;

`ifdef COMPLEMENT_ARB_BURST_EN
    localparam int CNT_W = $clog2(BURST_LEN + 1);
    logic [CNT_W-1:0] burst_cnt;
    logic             hold;

    // burst_cnt==0 means no owner yet, so the post-reset pointer never claims a burst
    assign hold  = (burst_cnt != '0) && (burst_cnt < CNT_W'(BURST_LEN)) &&
                   (|(bus.in_valid & (NUM_REQ'(1) << ptr)));
    assign start = hold ? ptr : next_ptr;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)  burst_cnt <= '0;
        else if (xfer) burst_cnt <= hold ? burst_cnt + 1'b1 : CNT_W'(1);
    end
`else
    assign start = next_ptr;
`endif

    // Rotate so the search origin sits at bit 0, then take the lowest set bit.
    assign dbl = {bus.in_valid, bus.in_valid} >> start;
    assign rot = dbl[NUM_REQ-1:0];

    always_comb begin
        offset = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) offset = SRC_WIDTH'(k);
        end
    end

    assign sum   = {1'b0, start} + {1'b0, offset};
    assign grant = (sum >= (SRC_WIDTH+1)'(NUM_REQ)) ? SRC_WIDTH'(sum - (SRC_WIDTH+1)'(NUM_REQ))
                                                    : SRC_WIDTH'(sum);

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant == SRC_WIDTH'(k)) sel_data = bus.in_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_source_q <= '0;
            ptr          <= SRC_WIDTH'(NUM_REQ - 1);
        end else if (xfer) begin
            out_valid_q  <= 1'b1;
            out_data_q   <= sel_data;
            out_source_q <= grant;
            ptr          <= grant;
        end else if (bus.out_ready) begin
            out_valid_q  <= 1'b0;
        end
    end

    assign bus.in_ready   = xfer ? (NUM_REQ'(1) << grant) : '0;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_source = out_source_q;
endmodule

// File: tb/tb_complement_base_arbiter.sv
// Bench for complement_base_arbiter: directed vector table, corner sequences, random vs model.
module tb_complement_base_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int SW = 2;
    localparam int BL = 4;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    complement_base_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .SRC_WIDTH(SW)) bus ();

    complement_base_arbiter #(
        .NUM_REQ(N), .DATA_WIDTH(DW), .SRC_WIDTH(SW), .BURST_LEN(BL)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: owner index, run length of the owner's current burst, output stage.
    int m_ptr, m_run, m_od, m_os;
    bit m_ov;
    int n_ptr, n_run, n_od, n_os;
    bit n_ov;
    int exp_rdy;

    typedef struct {
        logic [N-1:0]    v;
        logic [N*DW-1:0] d;
        logic            ordy;
        logic [N-1:0]    rdy;
        logic            ov;
        logic [DW-1:0]   od;
        logic [SW-1:0]   os;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_ptr = N - 1; m_run = 0; m_ov = 1'b0; m_od = 0; m_os = 0;
    endfunction

    function automatic void model_eval(input logic [N-1:0] v, input logic [N*DW-1:0] d,
                                       input logic ordy);
        int order[$];
        int g;
        bit keep;
        g    = -1;
        keep = 1'b0;
`ifdef COMPLEMENT_ARB_BURST_EN
        keep = (m_run > 0) && (m_run < BL) && (v[m_ptr] == 1'b1);
`endif
        for (int k = 0; k < N; k++) order.push_back((m_ptr + (keep ? 0 : 1) + k) % N);
        foreach (order[i]) if (g < 0 && v[order[i]] == 1'b1) g = order[i];
        n_ptr = m_ptr; n_run = m_run; n_ov = m_ov; n_od = m_od; n_os = m_os;
        exp_rdy = 0;
        if ((!m_ov || ordy == 1'b1) && g >= 0) begin
            exp_rdy = 1 << g;
            n_ov    = 1'b1;
            n_od    = int'(d[g*DW +: DW]);
            n_os    = g;
            n_ptr   = g;
            n_run   = (g == m_ptr && m_run > 0 && m_run < BL) ? m_run + 1 : 1;
        end else if (ordy == 1'b1) begin
            n_ov = 1'b0;
        end
    endfunction

    task automatic drive(input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic ordy);
        @(negedge clock);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = ordy;
        #1;
    endtask

    task automatic check_model(input string tag);
        model_eval(bus.in_valid, bus.in_data, bus.out_ready);
        chk({tag, ".in_ready"},   32'(bus.in_ready),   32'(exp_rdy));
        chk({tag, ".out_valid"},  32'(bus.out_valid),  32'(m_ov));
        chk({tag, ".out_data"},   32'(bus.out_data),   32'(m_od));
        chk({tag, ".out_source"}, 32'(bus.out_source), 32'(m_os));
        @(posedge clock);
        m_ptr = n_ptr; m_run = n_run; m_ov = n_ov; m_od = n_od; m_os = n_os;
    endtask

    task automatic step(input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic ordy,
                        input string tag);
        drive(v, d, ordy);
        check_model(tag);
    endtask

    // Asserts reset mid-cycle with whatever inputs are currently applied.
    task automatic apply_reset(input string tag);
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        chk({tag, ".in_ready"},   32'(bus.in_ready),   32'd0);
        chk({tag, ".out_valid"},  32'(bus.out_valid),  32'd0);
        chk({tag, ".out_data"},   32'(bus.out_data),   32'd0);
        chk({tag, ".out_source"}, 32'(bus.out_source), 32'd0);
        bus.in_valid  = '0;
        bus.out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] held;
        int beats;
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        model_reset();
        apply_reset("por");

        // Reset taken while a base is held in the output stage.
        for (int i = 0; i < 3; i++) step(4'b1111, 32'h13121110, 1'b0, "pre_rst");
        apply_reset("mid_rst");

`ifdef COMPLEMENT_ARB_BURST_EN
        for (int i = 0; i < 10; i++) begin
            tbl.push_back('{4'b0011, 32'h13121110, 1'b1,
                            (i >= 4 && i <= 7) ? 4'b0010 : 4'b0001,
                            i != 0,
                            (i >= 5 && i <= 8) ? 8'h11 : ((i == 0) ? 8'h00 : 8'h10),
                            (i >= 5 && i <= 8) ? 2'd1 : 2'd0});
        end
`else
        tbl.push_back('{4'b1111, 32'h13121110, 1'b1, 4'b0001, 1'b0, 8'h00, 2'd0});
        tbl.push_back('{4'b1111, 32'h13121110, 1'b1, 4'b0010, 1'b1, 8'h10, 2'd0});
        tbl.push_back('{4'b1111, 32'h13121110, 1'b1, 4'b0100, 1'b1, 8'h11, 2'd1});
        tbl.push_back('{4'b1111, 32'h13121110, 1'b1, 4'b1000, 1'b1, 8'h12, 2'd2});
        tbl.push_back('{4'b1111, 32'h13121110, 1'b1, 4'b0001, 1'b1, 8'h13, 2'd3});
        tbl.push_back('{4'b1111, 32'h13121110, 1'b1, 4'b0010, 1'b1, 8'h10, 2'd0});
`endif
        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].ordy);
            chk($sformatf("vec%0d.in_ready", i),   32'(bus.in_ready),   32'(tbl[i].rdy));
            chk($sformatf("vec%0d.out_valid", i),  32'(bus.out_valid),  32'(tbl[i].ov));
            chk($sformatf("vec%0d.out_data", i),   32'(bus.out_data),   32'(tbl[i].od));
            chk($sformatf("vec%0d.out_source", i), 32'(bus.out_source), 32'(tbl[i].os));
            check_model($sformatf("vec%0d", i));
        end

        // Lone requester 2 streams six bases back to back.
        beats = 0;
        for (int i = 0; i < 7; i++) begin
            drive((i < 6) ? 4'b0100 : 4'b0000, {$urandom}, 1'b1);
            if (i >= 1 && bus.out_valid === 1'b1 && bus.out_source === 2'd2) beats++;
            check_model("single");
        end
        chk("single.beats", 32'(beats), 32'd6);

        // Five-cycle downstream stall with everyone valid.
        step(4'b1111, 32'h23222120, 1'b1, "stall_fill");
        drive(4'b1111, 32'h23222120, 1'b0);
        held = bus.out_data;
        check_model("stall0");
        for (int i = 1; i < 5; i++) begin
            drive(4'b1111, 32'h23222120, 1'b0);
            chk($sformatf("stall%0d.hold", i), 32'(bus.out_data), 32'(held));
            chk($sformatf("stall%0d.rdy", i), 32'(bus.in_ready), 32'd0);
            check_model($sformatf("stall%0d", i));
        end
        for (int i = 0; i < 3; i++) step(4'b1111, 32'h23222120, 1'b1, "stall_rel");

        // Requester 1 withdraws while stuck behind a stall.
        step(4'b1111, 32'h33323130, 1'b0, "drop_a");
        step(4'b1101, 32'h33323130, 1'b0, "drop_b");
        for (int i = 0; i < 4; i++) begin
            drive(4'b1101, 32'h33323130, 1'b1);
            chk($sformatf("drop%0d.req1", i), 32'(bus.in_ready[1]), 32'd0);
            check_model($sformatf("drop%0d", i));
        end
        step(4'b0000, 32'h0, 1'b1, "drop_idle");

        // Random traffic against the model, with one reset in the middle.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) apply_reset("rnd_rst");
            step(4'($urandom_range(0, 15)), {$urandom}, ($urandom_range(0, 3) != 0),
                 $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
